// File: rtl/fifo_read_packer.sv
// Pops narrow words from an access-enable FIFO and packs RATIO of them into one
// wide word on a valid/ready output; flush emits a partially filled word.
module fifo_read_packer #(
  parameter int WIDTH       = 8,
  parameter int RATIO       = 4,
  parameter int COUNT_WIDTH = $clog2(RATIO + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fifo_empty,
  output logic                     fifo_read_enable,
  input  logic [WIDTH-1:0]         fifo_read_data,
  input  logic                     flush,
  output logic                     packed_valid,
  input  logic                     packed_ready,
  output logic [WIDTH*RATIO-1:0]   packed_data,
  output logic [COUNT_WIDTH-1:0]   packed_count
);

  localparam int IDX_W = $clog2(RATIO);

  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [RATIO-2:0][WIDTH-1:0]      acc_q, acc_d;
  logic                             out_valid_q, out_valid_d;
  logic [WIDTH*RATIO-1:0]           out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0]           out_count_q, out_count_d;

  logic out_free;
  logic last_lane;
  logic pop;
  logic flush_emit;

  always_comb begin
    out_free   = !out_valid_q || packed_ready;
    last_lane  = (idx_q == IDX_W'(RATIO - 1));
    pop        = !reset && !fifo_empty && !flush && (!last_lane || out_free);
    flush_emit = flush && (idx_q != '0) && out_free;

    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (out_valid_q && packed_ready) begin
      out_valid_d = 1'b0;
    end

    // Accumulator is cleared whenever a word leaves it, so unfilled lanes are
    // already zero when a flush emits a partial word.
    if (pop) begin
      if (last_lane) begin
        out_data_d  = {fifo_read_data, acc_q};
        out_count_d = COUNT_WIDTH'(RATIO);
        out_valid_d = 1'b1;
        idx_d       = '0;
        acc_d       = '0;
      end else begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (idx_q == IDX_W'(k)) begin
            acc_d[k] = fifo_read_data;
          end
        end
        idx_d = idx_q + 1'b1;
      end
    end else if (flush_emit) begin
      out_data_d  = {{WIDTH{1'b0}}, acc_q};
      out_count_d = COUNT_WIDTH'(idx_q);
      out_valid_d = 1'b1;
      idx_d       = '0;
      acc_d       = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign fifo_read_enable = pop;
  assign packed_valid     = out_valid_q;
  assign packed_data      = out_data_q;
  assign packed_count     = out_count_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Randomized bench for fifo_read_packer against a queue-based reference model,
// with directed full-rate, backpressure, flush and async-reset sequences.
module tb_fifo_read_packer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = $clog2(R + 1);

  logic            clock = 1'b0;
  logic            reset;
  logic            fifo_empty;
  logic            fifo_read_enable;
  logic [W-1:0]    fifo_read_data;
  logic            flush;
  logic            packed_valid;
  logic            packed_ready;
  logic [W*R-1:0]  packed_data;
  logic [CW-1:0]   packed_count;

  fifo_read_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clock            (clock),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .flush            (flush),
    .packed_valid     (packed_valid),
    .packed_ready     (packed_ready),
    .packed_data      (packed_data),
    .packed_count     (packed_count)
  );

  always #5 clock = ~clock;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // reference model: words popped but not yet emitted, plus the output register
  logic [W-1:0]   pend[$];
  logic           m_valid;
  logic [W*R-1:0] m_data;
  int unsigned    m_count;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W*R-1:0] pack_words();
    logic [W*R-1:0] v = '0;
    foreach (pend[k]) v[k*W +: W] = pend[k];
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_count = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance model at the rising edge.
  task automatic cycle(input bit e, input logic [W-1:0] d, input bit f, input bit r);
    bit exp_pop, drained, loaded;
    fifo_empty = e; fifo_read_data = d; flush = f; packed_ready = r;
    @(negedge clock);
    exp_pop = !e && !f && ((pend.size() < R - 1) || !m_valid || r);
    check_eq("rd_en", 64'(fifo_read_enable), 64'(exp_pop));
    check_eq("valid", 64'(packed_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("data", 64'(packed_data), 64'(m_data));
      check_eq("count", 64'(packed_count), 64'(m_count));
    end
    @(posedge clock);
    drained = m_valid && r;
    loaded  = 1'b0;
    if (exp_pop) begin
      pend.push_back(d);
      if (pend.size() == R) begin
        m_data = pack_words(); m_count = R; loaded = 1'b1; pend.delete();
      end
    end else if (f && pend.size() > 0 && (!m_valid || r)) begin
      m_data = pack_words(); m_count = pend.size(); loaded = 1'b1; pend.delete();
    end
    if (loaded) m_valid = 1'b1;
    else if (drained) m_valid = 1'b0;
    #1;
  endtask

  int unsigned pops;

  initial begin
    reset = 1'b1; fifo_empty = 1'b0; fifo_read_data = 8'h5A; flush = 1'b0; packed_ready = 1'b1;
    model_reset();
    #1;
    check_eq("rst_rd_en", 64'(fifo_read_enable), 64'd0);
    check_eq("rst_valid", 64'(packed_valid), 64'd0);
    check_eq("rst_data", 64'(packed_data), 64'd0);
    check_eq("rst_count", 64'(packed_count), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // full rate: 0x11..0x88
    pops = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'(i * 8'h11), 1'b0, 1'b1);
      if (fifo_read_enable === 1'b1 || pend.size() == 0 || i < 8) pops++;
      if (i == 4) begin
        check_eq("full_valid4", 64'(packed_valid), 64'd1);
        check_eq("full_w0", 64'(packed_data), 64'h44332211);
      end
    end
    check_eq("full_w1", 64'(packed_data), 64'h88776655);
    check_eq("full_c1", 64'(packed_count), 64'd4);
    cycle(1'b1, '0, 1'b0, 1'b1);

    // backpressure: first word held, three pops, then stall
    for (int i = 1; i <= 4; i++) cycle(1'b0, 8'(i * 8'h11), 1'b0, 1'b1);
    for (int i = 5; i <= 7; i++) cycle(1'b0, 8'(i * 8'h11), 1'b0, 1'b0);
    cycle(1'b0, 8'h88, 1'b0, 1'b0);
    check_eq("bp_hold", 64'(packed_data), 64'h44332211);
    cycle(1'b0, 8'h88, 1'b0, 1'b1);
    check_eq("bp_nobubble", 64'(packed_valid), 64'd1);
    check_eq("bp_next", 64'(packed_data), 64'h88776655);
    cycle(1'b1, '0, 1'b0, 1'b1);

    // flush partial, then flush with nothing pending
    cycle(1'b0, 8'hA1, 1'b0, 1'b1);
    cycle(1'b0, 8'hB2, 1'b0, 1'b1);
    cycle(1'b1, '0, 1'b1, 1'b1);
    check_eq("flush_data", 64'(packed_data), 64'h0000B2A1);
    check_eq("flush_count", 64'(packed_count), 64'd2);
    cycle(1'b1, '0, 1'b1, 1'b1);
    check_eq("flush_idle", 64'(packed_valid), 64'd0);

    // flush under stall
    for (int i = 1; i <= 5; i++) cycle(1'b0, 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h77, 1'b1, 1'b1);
    check_eq("fstall_data", 64'(packed_data), 64'h00000005);
    check_eq("fstall_count", 64'(packed_count), 64'd1);
    cycle(1'b1, '0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, '0, 1'b1, 1'b1);

    // async reset mid-packet with a held output word
    for (int i = 1; i <= 6; i++) cycle(1'b0, 8'(8'hF0 + i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(packed_valid), 64'd0);
    check_eq("arst_count", 64'(packed_count), 64'd0);
    check_eq("arst_rd_en", 64'(fifo_read_enable), 64'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) cycle(1'b0, 8'(i), 1'b0, 1'b1);
    check_eq("arst_word", 64'(packed_data), 64'h04030201);
    check_eq("arst_wcount", 64'(packed_count), 64'd4);
    cycle(1'b1, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Downstream consumer of an access-enable synchronous FIFO: it pops narrow words through the FIFO's empty / read_enable / read_data interface.
- It packs RATIO consecutive words into one wide word and presents it on a valid/ready output.
- It sits between a narrow FIFO and a wide datapath, such as a bus master or a wide memory write port.
- A flush input forces out a partially filled word, for end-of-packet or timeout cases.

Parameters:
- WIDTH, 8, width of one FIFO word.
- RATIO, 4, number of FIFO words packed per output word; must be ≥2.
- COUNT_WIDTH, derived as CLOG2(RATIO+1); width of packed_count; not to be overridden.

Ports:
- clock  input  1  system clock, all state rising-edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_enable  output  1  pop strobe to FIFO; a word is consumed on each rising edge where this is 1.
- fifo_read_data  input  WIDTH  FIFO head word; combinational, valid whenever fifo_empty=0.
- flush  input  1  level request to emit the current partial word.
- packed_valid  output  1  output word valid.
- packed_ready  input  1  downstream accepts; transfer occurs when packed_valid & packed_ready.
- packed_data  output  WIDTH*RATIO  packed word; lane k occupies bits [k*WIDTH +: WIDTH].
- packed_count  output  COUNT_WIDTH  number of valid lanes in packed_data (1..RATIO).

Behaviour:
- State:
  - lane index idx, range 0..RATIO-1.
  - accumulator holding lanes 0..RATIO-2.
  - output register: out_valid, out_data, out_count.
- Reset (async, any cycle, including mid-packet):
  - idx=0, accumulator=0, packed_valid=0, packed_data=0, packed_count=0.
  - Any partial word is discarded.
  - fifo_read_enable is forced to 0 while reset is high.
- out_free = !packed_valid | packed_ready.
- Pop rule:
  - fifo_read_enable = !reset & !fifo_empty & !flush & (idx<RATIO-1 | out_free).
  - Never asserted when fifo_empty=1.
- Pop with idx<RATIO-1:
  - lane idx of accumulator <= fifo_read_data.
  - idx <= idx+1.
  - Output register is untouched.
- Pop with idx=RATIO-1:
  - out_data <= {fifo_read_data, accumulator lanes RATIO-2..0}.
  - out_count <= RATIO, out_valid <= 1, idx <= 0.
  - The completed word never stalls in the accumulator.
- Word order: the first word popped lands in lane 0, the least significant lane.
- Latency:
  - packed_valid rises on the clock edge that pops the RATIO-th word.
  - First-word-in to word-out is RATIO cycles at full rate.
- Throughput: one FIFO word per cycle sustained while packed_ready=1, giving one packed word every RATIO cycles.
- Backpressure:
  - While packed_valid=1 and packed_ready=0, packed_data and packed_count hold stable.
  - Pops continue into lanes 0..RATIO-2, then stop at idx=RATIO-1 until out_free.
- Output handshake:
  - On packed_valid & packed_ready with no new load the same cycle, out_valid <= 0.
  - packed_data and packed_count retain their last value.
  - A drain and a load in the same cycle leave out_valid=1 with the new word, with no bubble.
- Flush (level, sampled each cycle):
  - While flush=1, no pops occur.
  - If idx>0 and out_free: out_data <= accumulator lanes 0..idx-1, upper lanes zero; out_count <= idx; out_valid <= 1; idx <= 0; accumulator cleared.
  - If idx>0 and !out_free: wait; emission happens on the first cycle out_free=1 while flush is still high.
  - If idx=0: no effect, and no empty word is ever emitted.
  - Holding flush high after emission only blocks pops.
- packed_count is always in the range 1..RATIO while packed_valid=1.
- idx wraps from RATIO-1 to 0 only on a last-lane pop or a flush emission.

Test Plan:
- Full-rate packing (WIDTH=8, RATIO=4): FIFO supplies 0x11,0x22,0x33,0x44,0x55..0x88 with packed_ready=1 → packed_data=0x44332211 with count 4, then 0x88776655 with count 4; fifo_read_enable is high on 8 consecutive cycles; packed_valid asserts on the 4th pop edge.
- Backpressure: packed_ready=0 after the first word, 7 words available → first word held stable; exactly 3 further pops (idx=3), then fifo_read_enable=0; raise packed_ready → 4th pop occurs the same cycle the first word drains, and the next word is 0x88776655 with no bubble.
- Flush partial: pop 0xA1,0xB2, then assert flush with empty FIFO → packed_data=0x0000B2A1, count 2; a second flush with idx=0 emits nothing.
- Flush under stall: output full with packed_ready=0, idx=1, flush=1 → no emission and no pops; packed_ready=1 → old word drains and partial 0x000000xx with count 1 loads the same edge.
- Empty FIFO: fifo_empty=1 throughout → fifo_read_enable never 1, packed_valid stays 0.
- Async reset mid-packet: reset after 2 pops, asserted between edges → packed_valid=0 and count=0 immediately; after release, the next 4 pops 0x01..0x04 produce 0x04030201, and the earlier lanes are lost.
